ram_bank_param: RTL

Parametrised single-port synchronous RAM bank for the shared 64-bit memory bus. It is the generalised successor to the fixed 256x64 RAM, with configurable width, depth, bank ID and read latency. It adds byte-enable writes, a valid/ready request handshake, a read-valid pipeline, and a post-reset memory-clear sequencer. Several instances sit on one bus, each decoding its own bank-select field; their outputs are OR-combined, with no tri-state.

---
 rtl/ram_bank_param.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ram_bank_param.sv
// Parametrised single-port synchronous RAM bank for a shared, OR-combined memory bus.
// Byte-enable writes, valid/ready requests, 1- or 2-cycle read latency, post-reset clear.
module ram_bank_param #(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned DEPTH_LOG2   = 8,
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned BANK_SEL_W   = 8,
    parameter int unsigned BANK_ID      = 0,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   address,
    input  logic                write,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic [DATA_W-1:0]   in,
    output logic [DATA_W-1:0]   out,
    output logic                out_valid,
    output logic                busy
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned NB    = DATA_W / 8;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("ram_bank_param: READ_LATENCY must be 1 or 2");
    end
    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("ram_bank_param: DATA_W must be a multiple of 8");
    end

    typedef enum logic [1:0] {StReset, StClear, StRun} state_e;

    state_e                  r_state, w_state_next;
    logic [DEPTH_LOG2-1:0]   r_ptr, w_ptr_next;
    logic                    w_clr_we;

    logic [DATA_W-1:0]       r_mem [DEPTH];

    logic [BANK_SEL_W-1:0]   w_sel;
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic                    w_hit, w_acc, w_wr, w_rd;

    logic                    r_vld1;
    logic [DATA_W-1:0]       r_dat1;
    logic                    w_vld_out;
    logic [DATA_W-1:0]       w_dat_out;
    logic                    w_unused;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StReset;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // The edge leaving StReset already clears word 0, so busy lasts exactly DEPTH cycles.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_clr_we     = 1'b0;
        unique case (r_state)
            StReset, StClear: begin
                w_clr_we     = 1'b1;
                w_ptr_next   = r_ptr + 1'b1;
                w_state_next = (r_ptr == '1) ? StRun : StClear;
            end
            StRun: begin
                w_state_next = StRun;
            end
            default: begin
                w_state_next = StReset;
            end
        endcase
    end

    always_comb begin
        req_ready = (r_state == StRun) && !reset;
        busy      = !req_ready;
    end

    assign w_sel    = address[ADDR_W-1 -: BANK_SEL_W];
    assign w_idx    = address[ADDR_W-BANK_SEL_W-1 -: DEPTH_LOG2];
    assign w_hit    = (w_sel == BANK_SEL_W'(BANK_ID));
    assign w_acc    = req_valid && req_ready;
    assign w_wr     = w_acc && w_hit && write;
    assign w_rd     = w_acc && w_hit && !write;
    assign w_unused = ^address;

    always_ff @(posedge clock) begin
        if (!reset && w_clr_we) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (byte_en[i]) begin
                    r_mem[w_idx][8*i +: 8] <= in[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld1 <= 1'b0;
        end else begin
            r_vld1 <= w_rd;
        end
        if (w_rd) begin
            r_dat1 <= r_mem[w_idx];
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic              r_vld2;
        logic [DATA_W-1:0] r_dat2;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_vld2 <= 1'b0;
            end else begin
                r_vld2 <= r_vld1;
            end
            if (r_vld1) begin
                r_dat2 <= r_dat1;
            end
        end

        assign w_vld_out = r_vld2;
        assign w_dat_out = r_dat2;
    end else begin : g_lat1
        assign w_vld_out = r_vld1;
        assign w_dat_out = r_dat1;
    end

    // Zero when idle so several banks can be OR-combined on the bus.
    assign out_valid = w_vld_out;
    assign out       = w_vld_out ? w_dat_out : '0;

endmodule
